regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Sequential reader that walks a contiguous range of the Registers block's read port and streams each value out over a valid/ready handshake.
- Serves as the debug/trace counterpart to the register file's write path. It sits beside the CPU register file on a spare read port (readRegister/readData) and feeds a debug UART or trace buffer.
- Reads only; it never drives regWrite.

Parameters:
DATA_WIDTH, 32, width of register values
ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request a dump; sampled only in IDLE
first_reg  input  ADDR_WIDTH  first register index; sampled with start
last_reg  input  ADDR_WIDTH  last register index, inclusive; sampled with start
read_register  output  ADDR_WIDTH  drives the register file read address
read_data  input  DATA_WIDTH  combinational read data from the register file
out_valid  output  1  out_data/out_index hold a word
out_ready  input  1  downstream accepts the word
out_data  output  DATA_WIDTH  captured register value
out_index  output  ADDR_WIDTH  index the value came from
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse after the last word transfers

Behaviour:
- Reset, asserted asynchronously:
  - state=IDLE
  - read_register=0, out_valid=0, out_data=0, out_index=0
  - busy=0, done=0
  - internal idx=0, last=0
- Reset asserted mid-dump aborts immediately. No partial-word handshake completes, and after release the block is in IDLE.
- States: IDLE, READ, SEND, DONE.
- IDLE:
  - read_register=0.
  - On start=1 at an edge: idx<=first_reg, last<=last_reg, go to READ.
- READ (one cycle):
  - read_register=idx, combinationally from the idx register.
  - At the edge: out_data<=read_data, out_index<=idx, out_valid<=1, go to SEND.
- SEND:
  - read_register holds idx.
  - out_data, out_index and out_valid stay stable while out_ready=0. There is no timeout.
  - Transfer occurs at an edge with out_valid=1 and out_ready=1. At that edge out_valid<=0, then:
    - if idx==last: go to DONE;
    - otherwise idx<=idx+1 (modulo 2**ADDR_WIDTH) and go to READ.
- DONE: done=1 for exactly this one cycle, busy=1; then go to IDLE.
- Latency and throughput:
  - start sampled at edge N → first out_valid visible after edge N+1.
  - One word per 2 cycles when out_ready is held high.
- Word count is ((last_reg - first_reg) mod 2**ADDR_WIDTH) + 1.
  - first_reg==last_reg → exactly 1 word.
  - first_reg>last_reg wraps through the top index to 0 and up to last_reg.
- start while busy is ignored, and first_reg/last_reg changes during a dump have no effect.
- start held high continuously: a new dump begins on the first edge in IDLE after DONE.
- The register file's writes during a dump are not blocked. The value captured is whatever read_data shows in the READ cycle.
- out_ready high while out_valid=0 has no effect.

Test Plan:
1. Reset and defaults: hold rst_n=0 → all outputs 0. Release rst_n with start=0 for 10 cycles → busy stays 0.
2. Full dump with back-pressure off:
   - Stimulus: preload reg i=i (reg 0 reads 0); first_reg=0, last_reg=31, start pulse, out_ready=1.
   - Required: exactly 32 transfers with (out_index, out_data)=(i, i) in order, 2 cycles apart; done pulses once, 1 cycle after the transfer of index 31; busy falls with it.
3. Back-pressure:
   - Stimulus: first_reg=3, last_reg=5, regs hold 0x30/0x40/0x50; out_ready=0 for 4 cycles on each word.
   - Required: out_data/out_index stay constant while stalled; words arrive as (3,0x30), (4,0x40), (5,0x50); no duplicates or drops.
4. Wrap and single word:
   - Stimulus A: first_reg=30, last_reg=1 → indices 30, 31, 0, 1 (4 words).
   - Stimulus B: first_reg=last_reg=7 → one word (7, reg7 value), then done.
5. Ignored start: with first_reg=0, last_reg=3 and start re-pulsed with first_reg=20 during the dump → only indices 0..3 are produced.
6. Reset mid-dump: assert rst_n=0 while in SEND at index 10 → out_valid, busy and read_register drop to 0 asynchronously. After release and a start with 0..0 → one clean word (0, 0).

Source files
------------

// File: rtl/regfile_dump_reader.sv
// Debug reader: walks a register range on a spare read port
// and streams each value out over a valid/ready handshake.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic [ADDR_WIDTH-1:0] read_register,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_SEND,
    S_DONE
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [ADDR_WIDTH-1:0] r_last;
  logic                  w_xfer;
  logic                  w_at_last;

  assign w_xfer    = (r_state == S_SEND) && out_valid && out_ready;
  assign w_at_last = (r_idx == r_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_READ;
      S_READ: w_next = S_SEND;
      S_SEND: begin
        if (w_xfer) w_next = w_at_last ? S_DONE : S_READ;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx     <= '0;
      r_last    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_idx  <= first_reg;
        r_last <= last_reg;
      end
      if (r_state == S_READ) begin
        out_data  <= read_data;
        out_index <= r_idx;
        out_valid <= 1'b1;
      end
      // Index wraps modulo the register count
      if (w_xfer) begin
        out_valid <= 1'b0;
        if (!w_at_last) r_idx <= r_idx + ADDR_WIDTH'(1);
      end
    end
  end

  assign read_register = (r_state == S_IDLE) ? '0 : r_idx;
  assign busy          = (r_state != S_IDLE);
  assign done          = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized bench for regfile_dump_reader against a
// queue-based model of the expected word stream.
module tb_regfile_dump_reader;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] first_reg = '0;
  logic [AW-1:0] last_reg = '0;
  logic [AW-1:0] read_register;
  logic [DW-1:0] read_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          busy;
  logic          done;

  logic [DW-1:0] regs [NR];
  assign read_data = regs[read_register];

  always #5 clk = ~clk;

  regfile_dump_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .first_reg(first_reg), .last_reg(last_reg),
    .read_register(read_register), .read_data(read_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index),
    .busy(busy), .done(done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] obs_idx[$];
  logic [DW-1:0] obs_data[$];
  int            obs_cyc[$];
  logic [AW-1:0] exp_idx[$];
  logic [DW-1:0] exp_data[$];
  int            done_cyc, done_cnt, stall_chg, first_valid;
  bit            timed_out;
  logic          busy_at_done, busy_after;

  task automatic build_expected(input int f, input int l);
    int n;
    exp_idx.delete();
    exp_data.delete();
    n = ((l - f + NR) % NR) + 1;
    for (int k = 0; k < n; k++) begin
      exp_idx.push_back(AW'((f + k) % NR));
      exp_data.push_back(regs[(f + k) % NR]);
    end
  endtask

  task automatic do_dump(input logic [AW-1:0] f, input logic [AW-1:0] l,
                         input int stall, input bit rnd, input bit poke);
    int wl;
    bit hp;
    logic [DW-1:0] pd;
    logic [AW-1:0] pi;
    obs_idx.delete(); obs_data.delete(); obs_cyc.delete();
    done_cyc = -1; done_cnt = 0; stall_chg = 0; first_valid = -1;
    timed_out = 0; busy_at_done = 0; busy_after = 1'bx;
    @(negedge clk);
    first_reg = f; last_reg = l; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; wl = stall; hp = 0; pd = '0; pi = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (poke && cyc == 3) begin
        start = 1'b1; first_reg = 20; last_reg = 25;
      end else if (poke && cyc == 4) begin
        start = 1'b0;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = cyc; busy_at_done = busy; end
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && hp && (out_data !== pd || out_index !== pi))
        stall_chg++;
      if (out_valid) begin
        if (rnd) out_ready = (($urandom % 3) != 0);
        else if (wl > 0) begin out_ready = 1'b0; wl--; end
        else out_ready = 1'b1;
      end else begin
        out_ready = rnd ? 1'($urandom % 2) : 1'b1;
      end
      if (out_valid && out_ready) begin
        obs_idx.push_back(out_index);
        obs_data.push_back(out_data);
        obs_cyc.push_back(cyc);
        hp = 0; wl = stall;
      end else if (out_valid) begin
        hp = 1; pd = out_data; pi = out_index;
      end
      if (done_cyc >= 0 && cyc == done_cyc + 2) begin
        busy_after = busy;
        break;
      end
      @(negedge clk);
    end
    if (done_cyc < 0) timed_out = 1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_cmp++;
    if ({out_valid, busy, done} !== 3'b000 || read_register !== '0 ||
        out_data !== '0 || out_index !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: v=%b b=%b d=%b rr=%0d od=%h oi=%0d want all 0",
               out_valid, busy, done, read_register, out_data, out_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_after_reset: cyc %0d busy=%b done=%b v=%b want 0",
                 i, busy, done, out_valid);
      end
    end
  endtask

  task automatic test_full_dump();
    int bad = 0;
    for (int i = 0; i < NR; i++) regs[i] = DW'(i);
    build_expected(0, 31);
    do_dump(0, 31, 0, 0, 0);
    n_cmp++;
    if (timed_out || obs_idx.size() != 32) begin
      n_bad++;
      $display("FAIL full_count: got %0d words timeout=%0b want 32",
               obs_idx.size(), timed_out);
    end else begin
      for (int i = 0; i < 32; i++) begin
        n_cmp++;
        if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL full_word %0d: got (%0d,%h) want (%0d,%h)", i,
                   obs_idx[i], obs_data[i], exp_idx[i], exp_data[i]);
        end
        if (i > 0 && obs_cyc[i] - obs_cyc[i-1] != 2) bad++;
      end
      n_cmp++;
      if (bad != 0 || first_valid != 1) begin
        n_bad++;
        $display("FAIL full_timing: gaps!=2 count %0d first_valid %0d want 0 / 1",
                 bad, first_valid);
      end
      n_cmp++;
      if (done_cnt != 1 || done_cyc != obs_cyc[31] + 1 ||
          busy_at_done !== 1'b1 || busy_after !== 1'b0) begin
        n_bad++;
        $display("FAIL full_done: cnt %0d at %0d busy %b/%b want 1 at %0d busy 1/0",
                 done_cnt, done_cyc, busy_at_done, busy_after, obs_cyc[31] + 1);
      end
    end
  endtask

  task automatic test_back_pressure();
    regs[3] = 32'h30; regs[4] = 32'h40; regs[5] = 32'h50;
    build_expected(3, 5);
    do_dump(3, 5, 4, 0, 0);
    n_cmp++;
    if (timed_out || obs_idx.size() != 3 || stall_chg != 0) begin
      n_bad++;
      $display("FAIL bp_stream: words %0d changes %0d timeout %0b want 3/0/0",
               obs_idx.size(), stall_chg, timed_out);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL bp_word %0d: got (%0d,%h) want (%0d,%h)", i,
                   obs_idx[i], obs_data[i], exp_idx[i], exp_data[i]);
        end
      end
      n_cmp++;
      if (obs_cyc[1] - obs_cyc[0] != 6 || done_cnt != 1) begin
        n_bad++;
        $display("FAIL bp_timing: gap %0d done %0d want 6 / 1",
                 obs_cyc[1] - obs_cyc[0], done_cnt);
      end
    end
  endtask

  task automatic test_wrap_single();
    int f [2] = '{30, 7};
    int l [2] = '{1, 7};
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < NR; i++) regs[i] = (i == 0) ? '0 : $urandom;
      build_expected(f[t], l[t]);
      do_dump(AW'(f[t]), AW'(l[t]), 0, 0, 0);
      n_cmp++;
      if (timed_out || obs_idx.size() != exp_idx.size() || done_cnt != 1) begin
        n_bad++;
        $display("FAIL wrap_count %0d..%0d: got %0d done %0d want %0d done 1",
                 f[t], l[t], obs_idx.size(), done_cnt, exp_idx.size());
      end else begin
        for (int i = 0; i < exp_idx.size(); i++) begin
          n_cmp++;
          if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== exp_data[i]) begin
            n_bad++;
            $display("FAIL wrap_word %0d: got (%0d,%h) want (%0d,%h)", i,
                     obs_idx[i], obs_data[i], exp_idx[i], exp_data[i]);
          end
        end
      end
    end
  endtask

  task automatic test_ignored_start();
    for (int i = 0; i < NR; i++) regs[i] = (i == 0) ? '0 : $urandom;
    build_expected(0, 3);
    do_dump(0, 3, 0, 0, 1);
    n_cmp++;
    if (timed_out || obs_idx.size() != 4 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL ign_count: got %0d words done %0d want 4 done 1",
               obs_idx.size(), done_cnt);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== exp_data[i]) begin
          n_bad++;
          $display("FAIL ign_word %0d: got (%0d,%h) want (%0d,%h)", i,
                   obs_idx[i], obs_data[i], exp_idx[i], exp_data[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    int f, l;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < NR; i++) regs[i] = (i == 0) ? '0 : $urandom;
      f = $urandom % NR;
      l = $urandom % NR;
      build_expected(f, l);
      do_dump(AW'(f), AW'(l), 0, 1, 0);
      n_cmp++;
      if (timed_out || obs_idx.size() != exp_idx.size() ||
          stall_chg != 0 || done_cnt != 1 || busy_after !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_stream %0d..%0d: words %0d/%0d chg %0d done %0d",
                 f, l, obs_idx.size(), exp_idx.size(), stall_chg, done_cnt);
      end else begin
        for (int i = 0; i < exp_idx.size(); i++) begin
          n_cmp++;
          if (obs_idx[i] !== exp_idx[i] || obs_data[i] !== exp_data[i]) begin
            n_bad++;
            $display("FAIL rnd_word %0d: got (%0d,%h) want (%0d,%h)", i,
                     obs_idx[i], obs_data[i], exp_idx[i], exp_data[i]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    bit hit = 0;
    for (int i = 0; i < NR; i++) regs[i] = (i == 0) ? '0 : $urandom;
    @(negedge clk);
    first_reg = 0; last_reg = 31; start = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (out_valid && out_index == 10) begin
        out_ready = 1'b0; hit = 1; break;
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if (!hit || read_register !== AW'(10)) begin
      n_bad++;
      $display("FAIL mid_reach: reached %0b read_register %0d want 1 / 10",
               hit, read_register);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || read_register !== '0) begin
      n_bad++;
      $display("FAIL mid_async: v=%b busy=%b rr=%0d want 0/0/0",
               out_valid, busy, read_register);
    end
    @(negedge clk);
    rst_n = 1'b1;
    build_expected(0, 0);
    do_dump(0, 0, 0, 0, 0);
    n_cmp++;
    if (timed_out || obs_idx.size() != 1 || done_cnt != 1) begin
      n_bad++;
      $display("FAIL mid_after: words %0d done %0d want 1 / 1",
               obs_idx.size(), done_cnt);
    end else if (obs_idx[0] !== exp_idx[0] || obs_data[0] !== exp_data[0]) begin
      n_bad++;
      $display("FAIL mid_word: got (%0d,%h) want (%0d,%h)",
               obs_idx[0], obs_data[0], exp_idx[0], exp_data[0]);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = '0;
    test_reset();
    test_full_dump();
    test_back_pressure();
    test_wrap_single();
    test_ignored_start();
    test_random();
    test_reset_mid_dump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
